// File: rtl/memory_bus_pkg.sv
// rtl/memory_bus_pkg.sv - shared states, region codes, I/O offsets and lane masks for memory_bus
package memory_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEM_READ_WAIT,
    MEM_READ_LATCH,
    MEM_WRITE,
    IO_ACCESS,
    DONE
  } bus_state_t;

  typedef enum logic [1:0] {
    REGION_MEM,
    REGION_IO,
    REGION_NONE
  } region_t;

  localparam logic [7:0] IO_PORT_OUT = 8'h00;
  localparam logic [7:0] IO_PORT_IN  = 8'h02;

  // Active-low lane masks: bit0 guards the low byte, bit1 the high byte
  localparam logic [1:0] MASK_WORD = 2'b00;
  localparam logic [1:0] MASK_LOW  = 2'b10;
  localparam logic [1:0] MASK_HIGH = 2'b01;
  localparam logic [1:0] MASK_NONE = 2'b11;

  function automatic logic [1:0] lane_mask(input logic is_byte, input logic odd);
    if (!is_byte) return MASK_WORD;
    return odd ? MASK_HIGH : MASK_LOW;
  endfunction

endpackage

// File: rtl/memory_bus_io.sv
// rtl/memory_bus_io.sv - I/O page registers (LED output port) and I/O read mux
module memory_bus_io
  import memory_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [7:0]  offset,
  input  logic [7:0]  wdata,
  input  logic [7:0]  port_in,
  output logic [7:0]  port_out,
  output logic [15:0] rdata
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out <= 8'h00;
    end else if (wr_en && offset == IO_PORT_OUT) begin
      port_out <= wdata;
    end
  end

  always_comb begin
    rdata = 16'h0000;
    case (offset)
      IO_PORT_OUT: rdata = {8'h00, port_out};
      IO_PORT_IN:  rdata = {8'h00, port_in};
      default:     rdata = 16'h0000;
    endcase
  end

endmodule

// File: rtl/memory_bus.sv
// rtl/memory_bus.sv - CPU-to-memory/I-O bus controller FSM with byte lane handling
// Optional MEMORY_BUS_ERROR_EN: fault odd word and unmapped accesses via bus_error.
module memory_bus
  import memory_bus_pkg::*;
#(
  parameter logic [15:0] MEM_TOP = 16'h1000,
  parameter logic [15:0] IO_BASE = 16'hff00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_address,
  input  logic [15:0] bus_data_in,
  output logic [15:0] bus_data_out,
  input  logic        bus_write,
  input  logic        bus_byte,
  input  logic        bus_start,
  output logic        bus_ready,
  output logic        bus_error,
  output logic [11:0] mem_address,
  output logic [15:0] mem_data_out,
  input  logic [15:0] mem_data_in,
  output logic [1:0]  mem_write_mask,
  output logic        mem_write_enable,
  output logic [7:0]  ioport_out,
  input  logic [7:0]  ioport_in
);

  bus_state_t  state;
  region_t     region_q;
  region_t     region_d;
  logic [7:0]  addr_q;
  logic [15:0] wdata_q;
  logic        write_q;
  logic        byte_q;
  logic        fault_q;
  logic        fault_d;
  logic [15:0] start_addr;
  logic [15:0] io_rdata;
  logic        io_wr_en;

  always_comb begin
    region_d = REGION_NONE;
    if (bus_address < MEM_TOP) begin
      region_d = REGION_MEM;
    end else if (bus_address[15:8] == IO_BASE[15:8]) begin
      region_d = REGION_IO;
    end
  end

`ifdef MEMORY_BUS_ERROR_EN
  assign fault_d = (!bus_byte && bus_address[0]) || (region_d == REGION_NONE);
`else
  assign fault_d = 1'b0;
`endif

  // Word accesses are forced even; a faulted access never reaches memory anyway
  assign start_addr = bus_byte ? bus_address : {bus_address[15:1], 1'b0};
  assign io_wr_en   = (state == IO_ACCESS) && write_q && !fault_q && (region_q == REGION_IO);

  memory_bus_io u_io (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (io_wr_en),
    .offset   (addr_q),
    .wdata    (wdata_q[7:0]),
    .port_in  (ioport_in),
    .port_out (ioport_out),
    .rdata    (io_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      region_q         <= REGION_NONE;
      addr_q           <= 8'h00;
      wdata_q          <= 16'h0000;
      write_q          <= 1'b0;
      byte_q           <= 1'b0;
      fault_q          <= 1'b0;
      bus_data_out     <= 16'h0000;
      bus_ready        <= 1'b0;
      bus_error        <= 1'b0;
      mem_address      <= 12'h000;
      mem_data_out     <= 16'h0000;
      mem_write_mask   <= MASK_NONE;
      mem_write_enable <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus_start) begin
            region_q    <= region_d;
            addr_q      <= start_addr[7:0];
            wdata_q     <= bus_data_in;
            write_q     <= bus_write;
            byte_q      <= bus_byte;
            fault_q     <= fault_d;
            mem_address <= start_addr[11:0];
            if (fault_d || region_d != REGION_MEM) begin
              state <= IO_ACCESS;
            end else if (bus_write) begin
              state            <= MEM_WRITE;
              mem_write_enable <= 1'b1;
              mem_write_mask   <= lane_mask(bus_byte, bus_address[0]);
              mem_data_out     <= bus_byte ? {2{bus_data_in[7:0]}} : bus_data_in;
            end else begin
              state <= MEM_READ_WAIT;
            end
          end
        end
        MEM_READ_WAIT: state <= MEM_READ_LATCH;
        MEM_READ_LATCH: begin
          if (byte_q) begin
            bus_data_out <= {8'h00, addr_q[0] ? mem_data_in[15:8] : mem_data_in[7:0]};
          end else begin
            bus_data_out <= mem_data_in;
          end
          bus_ready <= 1'b1;
          state     <= DONE;
        end
        MEM_WRITE: begin
          mem_write_enable <= 1'b0;
          mem_write_mask   <= MASK_NONE;
          bus_ready        <= 1'b1;
          state            <= DONE;
        end
        IO_ACCESS: begin
          if (!write_q && !fault_q) begin
            bus_data_out <= (region_q == REGION_IO) ? io_rdata : 16'h0000;
          end
          bus_ready <= 1'b1;
          bus_error <= fault_q;
          state     <= DONE;
        end
        DONE: begin
          bus_ready <= 1'b0;
          bus_error <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bus.sv
// tb/tb_memory_bus.sv - directed table-driven bench for memory_bus
module tb_memory_bus;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] bus_address = 16'h0000;
  logic [15:0] bus_data_in = 16'h0000;
  logic [15:0] bus_data_out;
  logic        bus_write = 1'b0;
  logic        bus_byte = 1'b0;
  logic        bus_start = 1'b0;
  logic        bus_ready;
  logic        bus_error;
  logic [11:0] mem_address;
  logic [15:0] mem_data_out;
  logic [15:0] mem_data_in = 16'h0000;
  logic [1:0]  mem_write_mask;
  logic        mem_write_enable;
  logic [7:0]  ioport_out;
  logic [7:0]  ioport_in = 8'h00;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  memory_bus dut (
    .clk              (clk),
    .reset            (reset),
    .bus_address      (bus_address),
    .bus_data_in      (bus_data_in),
    .bus_data_out     (bus_data_out),
    .bus_write        (bus_write),
    .bus_byte         (bus_byte),
    .bus_start        (bus_start),
    .bus_ready        (bus_ready),
    .bus_error        (bus_error),
    .mem_address      (mem_address),
    .mem_data_out     (mem_data_out),
    .mem_data_in      (mem_data_in),
    .mem_write_mask   (mem_write_mask),
    .mem_write_enable (mem_write_enable),
    .ioport_out       (ioport_out),
    .ioport_in        (ioport_in)
  );

  logic [15:0] mem [0:2047];
  int          we_total = 0;
  logic [1:0]  we_mask = 2'b11;
  logic [15:0] we_data = 16'h0000;
  logic [11:0] we_addr = 12'h000;
  int          mask_violations = 0;

  // Memory model: one-cycle registered read, active-low lane write mask
  always @(posedge clk) begin
    if (mem_write_enable) begin
      if (!mem_write_mask[0]) mem[mem_address[11:1]][7:0]  <= mem_data_out[7:0];
      if (!mem_write_mask[1]) mem[mem_address[11:1]][15:8] <= mem_data_out[15:8];
      we_total = we_total + 1;
      we_mask  = mem_write_mask;
      we_data  = mem_data_out;
      we_addr  = mem_address;
    end
    mem_data_in <= mem[mem_address[11:1]];
  end

  always @(negedge clk) begin
    if (!mem_write_enable && mem_write_mask !== 2'b11) mask_violations = mask_violations + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input logic [15:0] a, input logic [15:0] d, input logic w, input logic b,
                        output int lat, output logic [15:0] rd, output logic err,
                        output int nwe, output logic rdy_after);
    int we0;
    logic seen;
    we0 = we_total;
    bus_address = a;
    bus_data_in = d;
    bus_write   = w;
    bus_byte    = b;
    bus_start   = 1'b1;
    @(posedge clk);
    #1;
    bus_start = 1'b0;
    lat  = 0;
    rd   = 16'h0000;
    err  = 1'b0;
    seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!seen) begin
        @(posedge clk);
        #1;
        if (bus_ready) begin
          lat  = i;
          rd   = bus_data_out;
          err  = bus_error;
          seen = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    rdy_after = bus_ready;
    nwe = we_total - we0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic        byt;
    logic [7:0]  ioin;
    int          lat;
    logic        chk_data;
    logic [15:0] data;
    logic        err;
    int          nwe;
    logic [1:0]  mask;
    logic [15:0] mdata;
    logic [7:0]  port;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] addr, input logic [15:0] wdata, input logic wr,
                              input logic byt, input logic [7:0] ioin, input int lat,
                              input logic chk_data, input logic [15:0] data, input logic err,
                              input int nwe, input logic [1:0] mask, input logic [15:0] mdata,
                              input logic [7:0] port);
    vec_t v;
    v.addr = addr; v.wdata = wdata; v.wr = wr; v.byt = byt; v.ioin = ioin; v.lat = lat;
    v.chk_data = chk_data; v.data = data; v.err = err; v.nwe = nwe; v.mask = mask;
    v.mdata = mdata; v.port = port;
    return v;
  endfunction

  vec_t        vecs[$];
  int          lat;
  int          nwe;
  logic [15:0] rd;
  logic        err;
  logic        rdy_after;
  int          extra_ready;
  logic [11:0] exp_addr;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[11'h008] = 16'h1234;
    mem[11'h010] = 16'h5678;
    mem[11'h7ff] = 16'hc0de;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus_ready}, 32'd0);
    check("rst_error", {31'd0, bus_error}, 32'd0);
    check("rst_data", {16'd0, bus_data_out}, 32'd0);
    check("rst_we", {31'd0, mem_write_enable}, 32'd0);
    check("rst_mask", {30'd0, mem_write_mask}, 32'd3);
    check("rst_port", {24'd0, ioport_out}, 32'd0);
    check("rst_maddr", {20'd0, mem_address}, 32'd0);
    check("rst_mdata", {16'd0, mem_data_out}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    //                addr      wdata     wr    byt   ioin  lat chk  data      err   nwe mask   mdata     port
    vecs.push_back(mk(16'h0010, 16'h0000, 1'b0, 1'b0, 8'h00, 2, 1'b1, 16'h1234, 1'b0, 0, 2'b11, 16'h0000, 8'h00));
    vecs.push_back(mk(16'h0021, 16'h00ab, 1'b1, 1'b1, 8'h00, 1, 1'b0, 16'h0000, 1'b0, 1, 2'b01, 16'habab, 8'h00));
    vecs.push_back(mk(16'h0020, 16'h0000, 1'b0, 1'b0, 8'h00, 2, 1'b1, 16'hab78, 1'b0, 0, 2'b11, 16'h0000, 8'h00));
    vecs.push_back(mk(16'h0021, 16'h0000, 1'b0, 1'b1, 8'h00, 2, 1'b1, 16'h00ab, 1'b0, 0, 2'b11, 16'h0000, 8'h00));
    vecs.push_back(mk(16'h0020, 16'h0000, 1'b0, 1'b1, 8'h00, 2, 1'b1, 16'h0078, 1'b0, 0, 2'b11, 16'h0000, 8'h00));
    vecs.push_back(mk(16'h0020, 16'h12cd, 1'b1, 1'b1, 8'h00, 1, 1'b0, 16'h0000, 1'b0, 1, 2'b10, 16'hcdcd, 8'h00));
    vecs.push_back(mk(16'h0020, 16'h0000, 1'b0, 1'b0, 8'h00, 2, 1'b1, 16'habcd, 1'b0, 0, 2'b11, 16'h0000, 8'h00));
    vecs.push_back(mk(16'h0100, 16'hbeef, 1'b1, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b0, 1, 2'b00, 16'hbeef, 8'h00));
    vecs.push_back(mk(16'h0100, 16'h0000, 1'b0, 1'b0, 8'h00, 2, 1'b1, 16'hbeef, 1'b0, 0, 2'b11, 16'h0000, 8'h00));
    vecs.push_back(mk(16'hff00, 16'h0055, 1'b1, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'hff02, 16'h0000, 1'b0, 1'b0, 8'h0f, 1, 1'b1, 16'h000f, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'hff00, 16'h0000, 1'b0, 1'b0, 8'h0f, 1, 1'b1, 16'h0055, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'hff02, 16'h0000, 1'b0, 1'b1, 8'ha5, 1, 1'b1, 16'h00a5, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'hff04, 16'h0000, 1'b0, 1'b0, 8'h0f, 1, 1'b1, 16'h0000, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'hff02, 16'h0077, 1'b1, 1'b0, 8'h0f, 1, 1'b0, 16'h0000, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'h0ffe, 16'h0000, 1'b0, 1'b0, 8'h00, 2, 1'b1, 16'hc0de, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'h0fff, 16'h0000, 1'b0, 1'b1, 8'h00, 2, 1'b1, 16'h00c0, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
`ifdef MEMORY_BUS_ERROR_EN
    vecs.push_back(mk(16'h1000, 16'h0000, 1'b0, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b1, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'h0011, 16'h0000, 1'b0, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b1, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'h8000, 16'h0000, 1'b0, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b1, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'h2000, 16'h4444, 1'b1, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b1, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'hff01, 16'h0033, 1'b1, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b1, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'h0021, 16'h9999, 1'b1, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b1, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'h0020, 16'h0000, 1'b0, 1'b0, 8'h00, 2, 1'b1, 16'habcd, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
`else
    vecs.push_back(mk(16'h1000, 16'h0000, 1'b0, 1'b0, 8'h00, 1, 1'b1, 16'h0000, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'h0011, 16'h0000, 1'b0, 1'b0, 8'h00, 2, 1'b1, 16'h1234, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'h8000, 16'h0000, 1'b0, 1'b0, 8'h00, 1, 1'b1, 16'h0000, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'h2000, 16'h4444, 1'b1, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b0, 0, 2'b11, 16'h0000, 8'h55));
    vecs.push_back(mk(16'hff01, 16'h0033, 1'b1, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b0, 0, 2'b11, 16'h0000, 8'h33));
    vecs.push_back(mk(16'h0021, 16'h9999, 1'b1, 1'b0, 8'h00, 1, 1'b0, 16'h0000, 1'b0, 1, 2'b00, 16'h9999, 8'h33));
    vecs.push_back(mk(16'h0020, 16'h0000, 1'b0, 1'b0, 8'h00, 2, 1'b1, 16'h9999, 1'b0, 0, 2'b11, 16'h0000, 8'h33));
`endif

    for (int k = 0; k < vecs.size(); k++) begin
      ioport_in = vecs[k].ioin;
      access(vecs[k].addr, vecs[k].wdata, vecs[k].wr, vecs[k].byt, lat, rd, err, nwe, rdy_after);
      check($sformatf("v%0d_latency", k), lat, vecs[k].lat);
      check($sformatf("v%0d_error", k), {31'd0, err}, {31'd0, vecs[k].err});
      check($sformatf("v%0d_ready_pulse", k), {31'd0, rdy_after}, 32'd0);
      check($sformatf("v%0d_strobes", k), nwe, vecs[k].nwe);
      check($sformatf("v%0d_port", k), {24'd0, ioport_out}, {24'd0, vecs[k].port});
      if (vecs[k].chk_data) check($sformatf("v%0d_data", k), {16'd0, rd}, {16'd0, vecs[k].data});
      if (vecs[k].nwe == 1 && nwe == 1) begin
        exp_addr = vecs[k].byt ? vecs[k].addr[11:0] : {vecs[k].addr[11:1], 1'b0};
        check($sformatf("v%0d_mask", k), {30'd0, we_mask}, {30'd0, vecs[k].mask});
        check($sformatf("v%0d_mdata", k), {16'd0, we_data}, {16'd0, vecs[k].mdata});
        check($sformatf("v%0d_maddr", k), {20'd0, we_addr}, {20'd0, exp_addr});
      end
    end

    // bus_start pulsed during MEM_READ_LATCH must be ignored
    bus_address = 16'h0010;
    bus_write   = 1'b0;
    bus_byte    = 1'b0;
    bus_start   = 1'b1;
    @(posedge clk);
    #1;
    bus_start = 1'b0;
    @(posedge clk);
    #1;
    bus_address = 16'h0100;
    bus_start   = 1'b1;
    @(posedge clk);
    #1;
    bus_start = 1'b0;
    check("latch_ready", {31'd0, bus_ready}, 32'd1);
    check("latch_data", {16'd0, bus_data_out}, 32'h1234);
    extra_ready = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus_ready) extra_ready = extra_ready + 1;
    end
    check("latch_extra_ready", extra_ready, 0);

    // Reset asserted while in MEM_WRITE
    ioport_in = 8'h00;
    access(16'hff00, 16'h00c3, 1'b1, 1'b0, lat, rd, err, nwe, rdy_after);
    check("pre_rst_port", {24'd0, ioport_out}, 32'h00c3);
    bus_address = 16'h0040;
    bus_data_in = 16'h1111;
    bus_write   = 1'b1;
    bus_byte    = 1'b0;
    bus_start   = 1'b1;
    @(posedge clk);
    #1;
    bus_start = 1'b0;
    check("midwr_we_high", {31'd0, mem_write_enable}, 32'd1);
    reset = 1'b0;
    #1;
    check("midwr_we_drop", {31'd0, mem_write_enable}, 32'd0);
    check("midwr_mask", {30'd0, mem_write_mask}, 32'd3);
    check("midwr_port", {24'd0, ioport_out}, 32'd0);
    check("midwr_ready", {31'd0, bus_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    access(16'h0010, 16'h0000, 1'b0, 1'b0, lat, rd, err, nwe, rdy_after);
    check("post_rst_latency", lat, 2);
    check("post_rst_data", {16'd0, rd}, 32'h1234);
    check("mask_idle_violations", mask_violations, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_bus.md
# memory_bus

Bus controller between the PDP-11 CPU core and the 4 KiB word-organised memory block. It accepts one CPU access at a time through a start/ready handshake and decodes the 16-bit byte address into either the memory region or an I/O register page. It converts byte accesses into active-low lane write masks and lane-selected reads, and it sequences around the memory's one-cycle registered read latency.

## Interface
Parameters:
- MEM_TOP, 16'h1000: first byte address above the memory region (memory spans 0 .. MEM_TOP-1).
- IO_BASE, 16'hff00: base of the 256-byte I/O page.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- bus_address  in  16  CPU byte address; sampled with bus_start.
- bus_data_in  in  16  CPU write data; low byte used for byte writes.
- bus_data_out  out  16  read data; valid while bus_ready=1.
- bus_write  in  1  1=write, 0=read; sampled with bus_start.
- bus_byte  in  1  1=byte access, 0=word; sampled with bus_start.
- bus_start  in  1  request strobe; honoured only in IDLE.
- bus_ready  out  1  one-cycle completion pulse.
- bus_error  out  1  one-cycle pulse coincident with bus_ready on a faulted access.
- mem_address  out  12  byte address to memory (memory uses [11:1]).
- mem_data_out  out  16  write data to memory.
- mem_data_in  in  16  registered read data from memory.
- mem_write_mask  out  2  active-low lane mask; bit0=low byte, bit1=high byte.
- mem_write_enable  out  1  memory write strobe.
- ioport_out  out  8  output register (LED pins), at IO_BASE+0.
- ioport_in  in  8  input pins, read at IO_BASE+2.

## Operation
- States: IDLE, MEM_READ_WAIT, MEM_READ_LATCH, MEM_WRITE, IO_ACCESS, DONE.
- IDLE + bus_start: capture address, data, write and byte; decode the region; go to MEM_READ_WAIT, MEM_WRITE, or IO_ACCESS.
- bus_start in any other state is ignored, not queued.
- Region decode: address < MEM_TOP is memory; address[15:8] == IO_BASE[15:8] is I/O; anything else is unmapped.
- Word write: mem_write_mask=2'b00. Byte write at an even address: mask=2'b10. Byte write at an odd address: mask=2'b01. For byte writes, mem_data_out = {byte, byte}.
- Byte read: the lane is selected by address[0] and zero-extended into bus_data_out[7:0]. Word read returns mem_data_in unchanged.
- mem_write_mask=2'b11 whenever mem_write_enable=0.
- I/O reads:
  - IO_BASE+0 returns {8'h00, ioport_out}.
  - IO_BASE+2 returns {8'h00, ioport_in}.
  - Other I/O offsets return 0.
- I/O writes: a write to IO_BASE+0 loads ioport_out from the low byte. Writes to other I/O offsets are ignored.
- Unmapped read returns 16'h0000; unmapped write has no side effect. Both complete normally through DONE unless MEMORY_BUS_ERROR_EN is defined.

## Timing
- Reset values: all outputs 0 except mem_write_mask=2'b11. State returns to IDLE; ioport_out=8'h00.
- Memory read: bus_start sampled at edge E0.
  - MEM_READ_WAIT: mem_address is driven.
  - E1: memory registers its data.
  - MEM_READ_LATCH: lane selection is applied.
  - E2: bus_data_out is registered and state moves to DONE.
  - bus_ready is high in the cycle after E2, three cycles after start.
- Memory write: MEM_WRITE holds mem_write_enable=1 for exactly one cycle, then DONE. bus_ready comes two cycles after start.
- I/O access and unmapped access: one cycle in IO_ACCESS, then DONE. bus_ready comes two cycles after start.
- DONE lasts exactly one cycle, then IDLE. A new bus_start is accepted in the cycle after DONE.
- bus_data_out holds its value until the next read completes.
- Reset asserted mid-access: the access is aborted immediately and asynchronously, with no write strobe. A write already strobed may have committed.

## Configuration
- MEMORY_BUS_ERROR_EN defined: the following assert bus_error with bus_ready and perform no memory or I/O side effect:
  - a word access at an odd address;
  - any access to an unmapped address.
- MEMORY_BUS_ERROR_EN undefined:
  - bus_error is tied to 0;
  - a word access at an odd address is treated as an access to address & ~1;
  - an unmapped access behaves as described in Operation.

## Structure
- memory_bus_pkg holds:
  - the state enumeration;
  - I/O register offsets (IO_PORT_OUT=8'h00, IO_PORT_IN=8'h02);
  - mask constants (MASK_WORD=2'b00, MASK_LOW=2'b10, MASK_HIGH=2'b01, MASK_NONE=2'b11).
- One sub-module, memory_bus_io, holds the I/O page registers and the read mux; the FSM stays in memory_bus.

## Test plan
- Reset released, then word read of 16'h0010 with memory preloaded to 16'h1234 -> bus_ready on the third cycle after start, bus_data_out=16'h1234, bus_error=0.
- Byte write of 8'hab to 16'h0021 -> one-cycle mem_write_enable with mask 2'b01 and mem_data_out=16'habab; a following word read of 16'h0020 returns 16'habXX with the low byte unchanged.
- Write 16'h0055 to 16'hff00 -> ioport_out=8'h55; read of 16'hff02 with ioport_in=8'h0f -> bus_data_out=16'h000f.
- Word read of 16'h0011 and read of 16'h8000 -> with MEMORY_BUS_ERROR_EN: bus_error=1 and bus_ready=1 in the same cycle, no memory strobe. Without it: data from 16'h0010, and 16'h0000 with bus_error=0.
- bus_start pulsed during MEM_READ_LATCH -> ignored, exactly one bus_ready.
- reset asserted in MEM_WRITE -> mem_write_enable drops at once, state IDLE, ioport_out=0.
